// File: rtl/vga_fb_arbiter_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter: default widths,
// the issued-operation encoding and the fixed read latency.
package vga_fb_pkg;

    localparam int unsigned ADDR_W_DEF   = 15;
    localparam int unsigned COLOUR_W_DEF = 12;
    localparam int unsigned RD_LATENCY   = 3;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

endpackage

// File: rtl/vga_fb_arbiter_rr_pick.sv
// Combinational two-way round-robin picker: a lone eligible writer always
// wins; when both are eligible the one that did not win last time wins.
module fb_rr_pick (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic       grant_valid,
    output logic       grant_idx
);

    // Pick the winner among the eligible writers
    always_comb begin
        grant_valid = |eligible;
        grant_idx   = 1'b0;
        if (&eligible) begin
            grant_idx = ~last;
        end else begin
            grant_idx = eligible[1];
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer controller: the VGA pixel fetch has absolute
// priority, two writers share the remaining RAM cycles round-robin.
// Optional macro VGA_FB_ARB_STATS_EN enables the saturating STALL_COUNT.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_W        = ADDR_W_DEF,
    parameter int unsigned COLOUR_W      = COLOUR_W_DEF,
    parameter bit          WR_BLANK_ONLY = 1'b0
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                RD_REQ,
    input  logic [ADDR_W-1:0]   RD_ADDR,
    output logic [COLOUR_W-1:0] RD_DATA,
    output logic                RD_VALID,
    input  logic                DISP_ACTIVE,
    input  logic [1:0]          WR_REQ,
    input  logic [ADDR_W-1:0]   WR_ADDR0,
    input  logic [ADDR_W-1:0]   WR_ADDR1,
    input  logic [COLOUR_W-1:0] WR_DATA0,
    input  logic [COLOUR_W-1:0] WR_DATA1,
    output logic [1:0]          WR_ACK,
    output logic [ADDR_W-1:0]   RAM_ADDR,
    output logic                RAM_WE,
    output logic [COLOUR_W-1:0] RAM_WDATA,
    input  logic [COLOUR_W-1:0] RAM_RDATA,
    output logic [15:0]         STALL_COUNT
);

    localparam int unsigned TAG_DEPTH = RD_LATENCY - 1;

    op_e                  op_q;
    op_e                  op_d;
    logic                 last_q;
    logic [1:0]           just_q;
    logic [1:0]           eligible;
    logic                 blank_ok;
    logic                 grant_valid;
    logic                 grant_idx;
    logic [TAG_DEPTH-1:0] rd_tag;

    // A writer is masked for the cycle after its grant so a request still
    // high during its ack cycle is not taken as a second write.
    assign blank_ok = !WR_BLANK_ONLY || !DISP_ACTIVE;
    assign eligible = WR_REQ & ~just_q & {2{blank_ok}};

    fb_rr_pick u_pick (
        .eligible    (eligible),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Next operation: read first, then any eligible writer, else idle
    always_comb begin
        op_d = OP_IDLE;
        if (RD_REQ) begin
            op_d = OP_READ;
        end else if (grant_valid) begin
            op_d = OP_WRITE;
        end
    end

    // Issued-op register plus round-robin pointer and one-cycle write mask
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q   <= OP_IDLE;
            last_q <= 1'b1;
            just_q <= '0;
        end else begin
            op_q   <= op_d;
            just_q <= '0;
            if (op_d == OP_WRITE) begin
                last_q <= grant_idx;
                just_q <= {grant_idx, ~grant_idx};
            end
        end
    end

    // Registered RAM port and write acknowledge
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            WR_ACK    <= '0;
        end else begin
            WR_ACK <= '0;
            case (op_d)
                OP_READ: begin
                    RAM_ADDR <= RD_ADDR;
                end
                OP_WRITE: begin
                    RAM_ADDR  <= grant_idx ? WR_ADDR1 : WR_ADDR0;
                    RAM_WDATA <= grant_idx ? WR_DATA1 : WR_DATA0;
                    WR_ACK    <= {grant_idx, ~grant_idx};
                end
                default: begin
                end
            endcase
        end
    end

    assign RAM_WE = (op_q == OP_WRITE);

    // Read tag pipeline: tag[0] marks RAM data valid this cycle, the last
    // stage drives RD_VALID alongside the captured pixel.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rd_tag  <= '0;
            RD_DATA <= '0;
        end else begin
            rd_tag <= {rd_tag[TAG_DEPTH-2:0], (op_q == OP_READ)};
            if (rd_tag[0]) begin
                RD_DATA <= RAM_RDATA;
            end
        end
    end

    assign RD_VALID = rd_tag[TAG_DEPTH-1];

`ifdef VGA_FB_ARB_STATS_EN
    logic [15:0] stall_q;

    // Count cycles where a writer is waiting but no write is issued
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
        end else if ((|WR_REQ) && (op_d != OP_WRITE) && (stall_q != '1)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign STALL_COUNT = stall_q;
`else
    assign STALL_COUNT = '0;
`endif

endmodule
